// File: rtl/inst_buffer.sv
// Dual-push / dual-pop circular instruction queue between fetch and decode/dispatch.
// Optional IB_STATS_EN adds full/empty cycle counters (ib_full_cycles, ib_empty_cycles).
module inst_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid_inst0,
   input  logic              if_valid_inst1,
   input  logic [31:0]       if_IR0,
   input  logic [31:0]       if_IR1,
   input  logic [63:0]       if_NPC0,
   input  logic [63:0]       if_NPC1,
   input  logic              if_branch_taken0,
   input  logic              if_branch_taken1,
   input  logic [63:0]       if_pred_addr0,
   input  logic [63:0]       if_pred_addr1,
   input  logic [1:0]        id_dispatch_num,
   input  logic              ex_mem_flush,
   output logic [1:0]        ib_accept_num,
   output logic [PTR_W:0]    ib_count,
   output logic              id_valid_inst0,
   output logic              id_valid_inst1,
   output logic [31:0]       id_IR0,
   output logic [31:0]       id_IR1,
   output logic [63:0]       id_NPC0,
   output logic [63:0]       id_NPC1,
   output logic              id_branch_taken0,
   output logic              id_branch_taken1,
   output logic [63:0]       id_pred_addr0,
   output logic [63:0]       id_pred_addr1
`ifdef IB_STATS_EN
   ,
   output logic [31:0]       ib_full_cycles,
   output logic [31:0]       ib_empty_cycles
`endif
);

   localparam logic [31:0] NOP = 32'h47ff041f;

   typedef struct packed {
      logic [31:0] ir;
      logic [63:0] npc;
      logic        bt;
      logic [63:0] pa;
   } ib_entry_t;

   ib_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head, tail, head1, tail1;
   logic [PTR_W:0]   count;
   logic [1:0]       accept, push_req, push_n, disp, pop_n;
   ib_entry_t        e0, e1;

   // Credit is based on pre-pop occupancy, so IF never relies on a same-cycle dispatch.
   always_comb begin
      if (count == (PTR_W+1)'(DEPTH))        accept = 2'd0;
      else if (count == (PTR_W+1)'(DEPTH-1)) accept = 2'd1;
      else                                   accept = 2'd2;
      push_req = !if_valid_inst0 ? 2'd0 : (if_valid_inst1 ? 2'd2 : 2'd1);
      push_n   = (push_req > accept) ? accept : push_req;
      disp     = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
      pop_n    = ((PTR_W+1)'(disp) > count) ? count[1:0] : disp;
   end

   assign tail1 = tail + PTR_W'(1);
   assign head1 = head + PTR_W'(1);

   always_ff @(posedge clock) begin
      if (reset || ex_mem_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + PTR_W'(push_n);
         head  <= head + PTR_W'(pop_n);
         count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
      end
   end

   // Payload storage is never reset; readers are masked by the valid flags.
   always_ff @(posedge clock) begin
      if (!reset && !ex_mem_flush) begin
         if (push_n != 2'd0)
            mem[tail]  <= '{ir: if_IR0, npc: if_NPC0, bt: if_branch_taken0, pa: if_pred_addr0};
         if (push_n == 2'd2)
            mem[tail1] <= '{ir: if_IR1, npc: if_NPC1, bt: if_branch_taken1, pa: if_pred_addr1};
      end
   end

   assign e0 = mem[head];
   assign e1 = mem[head1];

   assign ib_accept_num    = accept;
   assign ib_count         = count;
   assign id_valid_inst0   = (count != '0);
   assign id_valid_inst1   = (count > (PTR_W+1)'(1));
   assign id_IR0           = id_valid_inst0 ? e0.ir  : NOP;
   assign id_NPC0          = id_valid_inst0 ? e0.npc : 64'd0;
   assign id_branch_taken0 = id_valid_inst0 & e0.bt;
   assign id_pred_addr0    = id_valid_inst0 ? e0.pa  : 64'd0;
   assign id_IR1           = id_valid_inst1 ? e1.ir  : NOP;
   assign id_NPC1          = id_valid_inst1 ? e1.npc : 64'd0;
   assign id_branch_taken1 = id_valid_inst1 & e1.bt;
   assign id_pred_addr1    = id_valid_inst1 ? e1.pa  : 64'd0;

`ifdef IB_STATS_EN
   // Counters survive flushes; they sample occupancy before this cycle's update.
   always_ff @(posedge clock) begin
      if (reset) begin
         ib_full_cycles  <= '0;
         ib_empty_cycles <= '0;
      end else begin
         if (count == (PTR_W+1)'(DEPTH)) ib_full_cycles  <= ib_full_cycles + 32'd1;
         if (count == '0)                ib_empty_cycles <= ib_empty_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue-based reference model fed by the driver,
// checked every cycle by an independent monitor.
module tb_inst_buffer;
   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam logic [31:0] NOP = 32'h47ff041f;

   typedef struct packed {
      logic [31:0] ir;
      logic [63:0] npc;
      logic        bt;
      logic [63:0] pa;
   } ent_t;

   logic clock = 1'b0;
   logic reset;
   logic if_valid_inst0, if_valid_inst1;
   logic [31:0] if_IR0, if_IR1;
   logic [63:0] if_NPC0, if_NPC1;
   logic if_branch_taken0, if_branch_taken1;
   logic [63:0] if_pred_addr0, if_pred_addr1;
   logic [1:0] id_dispatch_num;
   logic ex_mem_flush;
   logic [1:0] ib_accept_num;
   logic [PTR_W:0] ib_count;
   logic id_valid_inst0, id_valid_inst1;
   logic [31:0] id_IR0, id_IR1;
   logic [63:0] id_NPC0, id_NPC1;
   logic id_branch_taken0, id_branch_taken1;
   logic [63:0] id_pred_addr0, id_pred_addr1;
`ifdef IB_STATS_EN
   logic [31:0] ib_full_cycles, ib_empty_cycles;
   int unsigned exp_full, exp_empty;
`endif

   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;
   ent_t q[$];
   logic [63:0] next_npc = 64'h1000;

   always #5 clock = ~clock;

   inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock(clock), .reset(reset),
      .if_valid_inst0(if_valid_inst0), .if_valid_inst1(if_valid_inst1),
      .if_IR0(if_IR0), .if_IR1(if_IR1), .if_NPC0(if_NPC0), .if_NPC1(if_NPC1),
      .if_branch_taken0(if_branch_taken0), .if_branch_taken1(if_branch_taken1),
      .if_pred_addr0(if_pred_addr0), .if_pred_addr1(if_pred_addr1),
      .id_dispatch_num(id_dispatch_num), .ex_mem_flush(ex_mem_flush),
      .ib_accept_num(ib_accept_num), .ib_count(ib_count),
      .id_valid_inst0(id_valid_inst0), .id_valid_inst1(id_valid_inst1),
      .id_IR0(id_IR0), .id_IR1(id_IR1), .id_NPC0(id_NPC0), .id_NPC1(id_NPC1),
      .id_branch_taken0(id_branch_taken0), .id_branch_taken1(id_branch_taken1),
      .id_pred_addr0(id_pred_addr0), .id_pred_addr1(id_pred_addr1)
`ifdef IB_STATS_EN
      , .ib_full_cycles(ib_full_cycles), .ib_empty_cycles(ib_empty_cycles)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of stimulus and advances the reference model to the post-edge state.
   task automatic drive(input bit rst, input bit v0, input bit v1,
                        input logic [31:0] ir0, input logic [31:0] ir1,
                        input int disp, input bit fl);
      int acc, req, pn, popn, sz;
      ent_t s0, s1;
      @(negedge clock); #1;
      sz   = q.size();
      acc  = (DEPTH - sz < 2) ? DEPTH - sz : 2;
      req  = v0 ? (v1 ? 2 : 1) : 0;
      pn   = (req < acc) ? req : acc;
      popn = (disp > 2) ? 2 : disp;
      if (popn > sz) popn = sz;
      s0 = '{ir: ir0, npc: next_npc, bt: 1'($urandom), pa: {$urandom, $urandom}};
      s1 = '{ir: ir1, npc: (pn == 2) ? next_npc + 64'd4 : {$urandom, $urandom},
             bt: 1'($urandom), pa: {$urandom, $urandom}};
      next_npc = next_npc + 64'(4 * pn);
      reset = rst; ex_mem_flush = fl; id_dispatch_num = 2'(disp);
      if_valid_inst0 = v0; if_valid_inst1 = v1;
      if_IR0 = s0.ir; if_NPC0 = s0.npc; if_branch_taken0 = s0.bt; if_pred_addr0 = s0.pa;
      if_IR1 = s1.ir; if_NPC1 = s1.npc; if_branch_taken1 = s1.bt; if_pred_addr1 = s1.pa;
`ifdef IB_STATS_EN
      if (rst) begin exp_full = 0; exp_empty = 0; end
      else begin
         if (sz == DEPTH) exp_full++;
         if (sz == 0)     exp_empty++;
      end
`endif
      if (rst || fl) q.delete();
      else begin
         for (int i = 0; i < popn; i++) void'(q.pop_front());
         if (pn >= 1) q.push_back(s0);
         if (pn == 2) q.push_back(s1);
      end
   endtask

   // Monitor: compares the visible DUT state against the model every cycle.
   always @(negedge clock) begin
      if (mon_en) begin
         ent_t z0, z1;
         int   sz;
         sz = q.size();
         z0 = '{ir: NOP, npc: 64'd0, bt: 1'b0, pa: 64'd0};
         z1 = z0;
         if (sz > 0) z0 = q[0];
         if (sz > 1) z1 = q[1];
         chk("count",  64'(ib_count), 64'(sz));
         chk("accept", 64'(ib_accept_num), 64'((DEPTH - sz < 2) ? DEPTH - sz : 2));
         chk("valid0", 64'(id_valid_inst0), 64'(sz > 0));
         chk("valid1", 64'(id_valid_inst1), 64'(sz > 1));
         chk("IR0",  64'(id_IR0), 64'(z0.ir));
         chk("NPC0", id_NPC0, z0.npc);
         chk("BT0",  64'(id_branch_taken0), 64'(z0.bt));
         chk("PA0",  id_pred_addr0, z0.pa);
         chk("IR1",  64'(id_IR1), 64'(z1.ir));
         chk("NPC1", id_NPC1, z1.npc);
         chk("BT1",  64'(id_branch_taken1), 64'(z1.bt));
         chk("PA1",  id_pred_addr1, z1.pa);
         if (id_valid_inst0 && id_valid_inst1)
            chk("npc_seq", id_NPC1, id_NPC0 + 64'd4);
`ifdef IB_STATS_EN
         chk("full_cycles",  64'(ib_full_cycles),  64'(exp_full));
         chk("empty_cycles", 64'(ib_empty_cycles), 64'(exp_empty));
`endif
      end
   end

   initial begin
      reset = 1'b1; ex_mem_flush = 1'b0; id_dispatch_num = 2'd0;
      if_valid_inst0 = 1'b0; if_valid_inst1 = 1'b0;
      if_IR0 = '0; if_IR1 = '0; if_NPC0 = '0; if_NPC1 = '0;
      if_branch_taken0 = 1'b0; if_branch_taken1 = 1'b0;
      if_pred_addr0 = '0; if_pred_addr1 = '0;
`ifdef IB_STATS_EN
      exp_full = 0; exp_empty = 0;
`endif
      @(posedge clock); #1;
      mon_en = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0);                                 // second reset cycle
      // in-order visibility then single dispatch
      drive(0, 1, 1, 32'h11111111, 32'h22222222, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 2, 0);                                 // dispatch 2 with count=1
      // fill to full, overflow attempt, then drain
      for (int i = 0; i < 4; i++) drive(0, 1, 1, $urandom, $urandom, 0, 0);
      drive(0, 1, 1, $urandom, $urandom, 0, 0);
      drive(0, 1, 1, $urandom, $urandom, 2, 0);                   // full: push ignored, pop 2
      drive(0, 0, 0, 0, 0, 2, 0);
      drive(0, 0, 0, 0, 0, 3, 0);                                 // dispatch 3 at count=4
      for (int i = 0; i < 10; i++) drive(0, 1, 1, $urandom, $urandom, 2, 0);
      // build count=5, then flush with concurrent push/pop
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 1, 1, $urandom, $urandom, 0, 0);
      drive(0, 1, 1, $urandom, $urandom, 0, 0);
      drive(0, 1, 0, $urandom, $urandom, 0, 0);
      drive(0, 1, 1, $urandom, $urandom, 2, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      // slot1 without slot0 is ignored; single-slot credit at DEPTH-1
      drive(0, 0, 1, $urandom, $urandom, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, (i != 3), $urandom, $urandom, 0, 0);
      drive(0, 1, 1, $urandom, $urandom, 0, 0);
      drive(1, 1, 1, $urandom, $urandom, 1, 0);                   // mid-operation reset
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom, $urandom,
               int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clock); #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
